// File: rtl/ctrl_decode_pipe_if.sv
// ctrl_decode_pipe_if: IF/ID-side inputs and ID/EX-stage outputs of the
// pipelined decode stage. The upstream/EX side uses the master modport and
// the decode stage itself uses the slave modport.
interface ctrl_decode_pipe_if #(
  parameter int DATA_W  = 32,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
);

  // IF/ID and EX-side controls into the decode stage
  logic [31:0]        instr;
  logic               if_valid;
  logic               ex_ready;
  logic               flush;

  // Hazard control back to fetch
  logic               stall;

  // ID/EX stage contents
  logic               ex_valid;
  logic [1:0]         ex_reg_dst;
  logic               ex_branch;
  logic               ex_branch_ne;
  logic               ex_mem_read;
  logic               ex_mem_write;
  logic               ex_alu_src;
  logic               ex_reg_write;
  logic               ex_jump;
  logic               ex_pc_src;
  logic [1:0]         ex_mem_to_reg;
  logic [ALUOP_W-1:0] ex_alu_op;
  logic               ex_illegal;
  logic [4:0]         ex_rs;
  logic [4:0]         ex_rt;
  logic [4:0]         ex_wreg;
  logic [4:0]         ex_shamt;
  logic [DATA_W-1:0]  ex_imm;

  // Load-use bubble statistics
  logic [CNT_W-1:0]   bubble_cnt;

  modport master (
    output instr, if_valid, ex_ready, flush,
    input  stall, ex_valid, ex_reg_dst, ex_branch, ex_branch_ne,
           ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_write, ex_jump,
           ex_pc_src, ex_mem_to_reg, ex_alu_op, ex_illegal, ex_rs, ex_rt,
           ex_wreg, ex_shamt, ex_imm, bubble_cnt
  );

  modport slave (
    input  instr, if_valid, ex_ready, flush,
    output stall, ex_valid, ex_reg_dst, ex_branch, ex_branch_ne,
           ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_write, ex_jump,
           ex_pc_src, ex_mem_to_reg, ex_alu_op, ex_illegal, ex_rs, ex_rt,
           ex_wreg, ex_shamt, ex_imm, bubble_cnt
  );

endinterface

// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe: decodes the IF/ID instruction into a full control word,
// destination register and extended immediate, and registers the result as
// the ID/EX stage. Inserts one bubble on a load-use hazard, holds under EX
// back-pressure and kills the decoding instruction on a taken branch/jump.
// A saturating counter records inserted load-use bubbles.
// The module parameters must match those of the connected interface.
module ctrl_decode_pipe #(
  parameter int DATA_W  = 32,  // >= 16
  parameter int ALUOP_W = 4,   // >= 4, upper bits always zero
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,   // asynchronous, active low
  ctrl_decode_pipe_if.slave  bus
);

  // Primary opcodes
  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_ORI   = 6'h0D,
    OP_XORI  = 6'h16,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  // R-type function codes
  typedef enum logic [5:0] {
    FN_SLL = 6'h00,
    FN_SRL = 6'h02,
    FN_JR  = 6'h08,
    FN_SGT = 6'h14,
    FN_XOR = 6'h15,
    FN_ADD = 6'h20,
    FN_SUB = 6'h22,
    FN_AND = 6'h24,
    FN_OR  = 6'h25,
    FN_NOR = 6'h27,
    FN_SLT = 6'h2A
  } funct_e;

  // ALU operation encodings
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4,
    ALU_SGT = 4'd5,
    ALU_NOR = 4'd6,
    ALU_XOR = 4'd7,
    ALU_SLL = 4'd8,
    ALU_SRL = 4'd9
  } alu_op_e;

  // One ID/EX entry; an all-zero entry is a bubble
  typedef struct packed {
    logic               valid;
    logic [1:0]         reg_dst;
    logic               branch;
    logic               branch_ne;
    logic               mem_read;
    logic               mem_write;
    logic               alu_src;
    logic               reg_write;
    logic               jump;
    logic               pc_src;
    logic [1:0]         mem_to_reg;
    logic [ALUOP_W-1:0] alu_op;
    logic               illegal;
    logic [4:0]         rs;
    logic [4:0]         rt;
    logic [4:0]         wreg;
    logic [4:0]         shamt;
    logic [DATA_W-1:0]  imm;
  } idex_t;

  // Instruction fields
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;

  assign opcode = bus.instr[31:26];
  assign rs     = bus.instr[25:21];
  assign rt     = bus.instr[20:16];
  assign rd     = bus.instr[15:11];
  assign shamt  = bus.instr[10:6];
  assign funct  = bus.instr[5:0];
  assign imm16  = bus.instr[15:0];

  // Extended immediates
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;

  assign imm_sext = DATA_W'($signed(imm16));
  assign imm_zext = DATA_W'(imm16);

  // Decode results
  idex_t      dec;
  logic       uses_rs;
  logic       uses_rt;
  logic       r_legal;
  logic [3:0] r_op;

  // Hazard detection and stage state
  logic       load_use;
  idex_t      ex_d, ex_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Combinational decode of the IF/ID instruction
  always_comb begin
    // NOTE: every variable written here gets a default first; a path that
    // left one unassigned would imply storage and infer a latch.
    dec       = '0;
    uses_rs   = 1'b0;
    uses_rt   = 1'b0;
    r_legal   = 1'b1;
    r_op      = ALU_ADD;
    dec.rs    = rs;
    dec.rt    = rt;
    dec.shamt = shamt;

    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  r_op = ALU_ADD;
          FN_SUB:  r_op = ALU_SUB;
          FN_AND:  r_op = ALU_AND;
          FN_OR:   r_op = ALU_OR;
          FN_SLT:  r_op = ALU_SLT;
          FN_SGT:  r_op = ALU_SGT;
          FN_NOR:  r_op = ALU_NOR;
          FN_XOR:  r_op = ALU_XOR;
          FN_SLL:  r_op = ALU_SLL;
          FN_SRL:  r_op = ALU_SRL;
          FN_JR:   r_op = ALU_ADD;
          default: r_legal = 1'b0;
        endcase

        if (!r_legal) begin
          dec.illegal = 1'b1;
        end else if (funct == FN_JR) begin
          dec.pc_src = 1'b1;
          uses_rs    = 1'b1;
        end else begin
          dec.reg_dst   = 2'd1;
          dec.reg_write = 1'b1;
          dec.alu_op    = ALUOP_W'(r_op);
          uses_rt       = 1'b1;
          // Shifts take their amount from shamt, not from rs
          uses_rs       = (funct != FN_SLL) && (funct != FN_SRL);
        end
      end

      OP_ADDI: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = ALUOP_W'(ALU_ADD);
        dec.imm       = imm_sext;
        uses_rs       = 1'b1;
      end

      OP_ORI: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = ALUOP_W'(ALU_OR);
        dec.imm       = imm_zext;
        uses_rs       = 1'b1;
      end

      OP_XORI: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = ALUOP_W'(ALU_XOR);
        dec.imm       = imm_zext;
        uses_rs       = 1'b1;
      end

      OP_LW: begin
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 2'd1;
        dec.alu_src    = 1'b1;
        dec.reg_write  = 1'b1;
        dec.imm        = imm_sext;
        uses_rs        = 1'b1;
      end

      OP_SW: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm       = imm_sext;
        uses_rs       = 1'b1;
        uses_rt       = 1'b1;
      end

      OP_BEQ, OP_BNE: begin
        dec.branch    = 1'b1;
        dec.branch_ne = (opcode == OP_BNE);
        dec.alu_op    = ALUOP_W'(ALU_SUB);
        dec.imm       = imm_sext;
        uses_rs       = 1'b1;
        uses_rt       = 1'b1;
      end

      OP_JAL: begin
        dec.jump       = 1'b1;
        dec.reg_dst    = 2'd2;
        dec.mem_to_reg = 2'd2;
        dec.reg_write  = 1'b1;
      end

      default: dec.illegal = 1'b1;
    endcase

    // Resolve the destination register from reg_dst
    case (dec.reg_dst)
      2'd1:    dec.wreg = rd;
      2'd2:    dec.wreg = 5'd31;
      default: dec.wreg = rt;
    endcase
  end

  // A load in EX whose target is read by the instruction in ID
  assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.wreg != 5'd0) &&
                    ((uses_rs && (rs == ex_q.wreg)) ||
                     (uses_rt && (rt == ex_q.wreg)));

  // Freeze PC and IF/ID on back-pressure or a hazard not overridden by flush
  assign bus.stall = !bus.ex_ready ||
                     (bus.if_valid && load_use && !bus.flush);

  // ID/EX next state: flush, then hold, then bubble, then normal load
  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (bus.flush) begin
      ex_d = '0;
    end else if (!bus.ex_ready) begin
      ex_d = ex_q;
    end else if (bus.if_valid && load_use) begin
      ex_d = '0;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      ex_d       = dec;
      ex_d.valid = bus.if_valid;
    end
  end

  // ID/EX stage and bubble counter registers
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_reg_dst    = ex_q.reg_dst;
  assign bus.ex_branch     = ex_q.branch;
  assign bus.ex_branch_ne  = ex_q.branch_ne;
  assign bus.ex_mem_read   = ex_q.mem_read;
  assign bus.ex_mem_write  = ex_q.mem_write;
  assign bus.ex_alu_src    = ex_q.alu_src;
  assign bus.ex_reg_write  = ex_q.reg_write;
  assign bus.ex_jump       = ex_q.jump;
  assign bus.ex_pc_src     = ex_q.pc_src;
  assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
  assign bus.ex_alu_op     = ex_q.alu_op;
  assign bus.ex_illegal    = ex_q.illegal;
  assign bus.ex_rs         = ex_q.rs;
  assign bus.ex_rt         = ex_q.rt;
  assign bus.ex_wreg       = ex_q.wreg;
  assign bus.ex_shamt      = ex_q.shamt;
  assign bus.ex_imm        = ex_q.imm;
  assign bus.bubble_cnt    = cnt_q;

endmodule
